// File: rtl/axi_tg_pkg.sv
// Shared types and constants for the AXI write/read-back traffic generator.
package axi_tg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } state_e;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  // Galois right-shift mask for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;

  function automatic logic [2:0] axi_size(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi_tg_lfsr.sv
// Galois LFSR pattern source; built only when AXI_TG_LFSR_EN is defined.
`ifdef AXI_TG_LFSR_EN
module axi_tg_lfsr
  import axi_tg_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] value
);

  // A zero seed would lock the LFSR, so it is replaced by 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= (seed == '0) ? W'(1) : seed;
    end else if (enable) begin
      value <= value[0] ? ((value >> 1) ^ W'(LFSR_TAPS)) : (value >> 1);
    end
  end

endmodule
`endif

// File: rtl/axi_traffic_gen.sv
// Single AXI master: one INCR write burst, then a read-back burst compared against the same pattern.
// Optional macro AXI_TG_LFSR_EN selects an LFSR data pattern instead of seed+k.
module axi_traffic_gen
  import axi_tg_pkg::*;
#(
  parameter int unsigned ID_W   = 4,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [7:0]          len,
  input  logic [ID_W-1:0]     tid,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [8:0]          err_cnt,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  input  logic [ID_W-1:0]     bid,
  output logic                bready,
  output logic                arvalid,
  input  logic                arready,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rlast
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam logic [2:0]  AX_SIZE = axi_size(STRB_W);

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [ID_W-1:0]     tid_q;
  logic [DATA_W-1:0]   seed_q;
  logic [DATA_W-1:0]   pat;
  logic [8:0]          beat_q, beat_nxt;
  logic [8:0]          err_nxt;
  logic [9:0]          err_sum;
  logic [1:0]          err_inc;
  logic                aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                pat_load, pat_step, data_bad, rlast_bad;
  logic                awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d, busy_d, done_d;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign b_hs  = bvalid && bready;
  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awlen   = len_q;
  assign arlen   = len_q;
  assign awid    = tid_q;
  assign arid    = tid_q;
  assign awsize  = AX_SIZE;
  assign arsize  = AX_SIZE;
  assign awburst = AXI_BURST_INCR;
  assign arburst = AXI_BURST_INCR;
  assign wdata   = pat;
  assign wstrb   = {STRB_W{wvalid}};

  // Pattern restarts at P(0) at the start of both the write and the read burst
  assign pat_load = (state == S_AW && aw_hs) || (state == S_AR && ar_hs);
  assign pat_step = (state == S_W && w_hs) || (state == S_R && r_hs);
  assign beat_nxt = pat_load ? 9'd0 : (pat_step ? beat_q + 9'd1 : beat_q);

`ifdef AXI_TG_LFSR_EN
  axi_tg_lfsr #(.W(DATA_W)) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (pat_step),
    .load   (pat_load),
    .seed   (seed_q),
    .value  (pat)
  );
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        pat <= '0;
    else if (pat_load) pat <= seed_q;
    else if (pat_step) pat <= pat + DATA_W'(1);
  end
`endif

  // Error accounting: bad BID, bad data/id per beat, misplaced or missing RLAST
  assign data_bad  = (rdata != pat) || (rid != tid_q);
  assign rlast_bad = rlast ? (beat_q < 9'(len_q)) : (beat_q == 9'(len_q));

  always_comb begin
    err_inc = 2'd0;
    if (state == S_B && b_hs && bid != tid_q) err_inc = 2'd1;
    if (state == S_R && r_hs)                 err_inc = 2'(data_bad) + 2'(rlast_bad);
  end

  assign err_sum = 10'(err_cnt) + 10'(err_inc);
  assign err_nxt = err_sum[9] ? 9'h1FF : err_sum[8:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start)          state_nxt = S_AW;
      S_AW:   if (aw_hs)          state_nxt = S_W;
      S_W:    if (w_hs && wlast)  state_nxt = S_B;
      S_B:    if (b_hs)           state_nxt = S_AR;
      S_AR:   if (ar_hs)          state_nxt = S_R;
      S_R:    if (r_hs && rlast)  state_nxt = S_DONE;
      S_DONE:                     state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Channel controls decoded from the next state so they are registered outputs
  always_comb begin
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    bready_d  = 1'b0;
    arvalid_d = 1'b0;
    rready_d  = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_nxt)
      S_AW:    begin awvalid_d = 1'b1; busy_d = 1'b1; end
      S_W:     begin wvalid_d  = 1'b1; busy_d = 1'b1; end
      S_B:     begin bready_d  = 1'b1; busy_d = 1'b1; end
      S_AR:    begin arvalid_d = 1'b1; busy_d = 1'b1; end
      S_R:     begin rready_d  = 1'b1; busy_d = 1'b1; end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= '0;
      tid_q   <= '0;
      seed_q  <= '0;
      beat_q  <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
      wlast   <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      arvalid <= 1'b0;
      rready  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        addr_q  <= base_addr;
        len_q   <= len;
        tid_q   <= tid;
        seed_q  <= seed;
        err_cnt <= '0;
        pass    <= 1'b0;
      end else begin
        err_cnt <= err_nxt;
        if (state_nxt == S_DONE) pass <= (err_nxt == '0);
      end
      beat_q  <= beat_nxt;
      wlast   <= (state_nxt == S_W) && (beat_nxt == 9'(len_q));
      awvalid <= awvalid_d;
      wvalid  <= wvalid_d;
      bready  <= bready_d;
      arvalid <= arvalid_d;
      rready  <= rready_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: doc/axi_traffic_gen.md
AXI_TRAFFIC_GEN -- requirements
Module: axi_traffic_gen

Interface
REQ-001 SHALL have parameter ID_W, default 4, width of AXI ID fields.
REQ-002 SHALL have parameter ADDR_W, default 16, width of AXI addresses.
REQ-003 SHALL have parameter DATA_W, default 32, width of AXI data; WSTRB is DATA_W/8.
REQ-004 SHALL have port clk  input  1  single clock for all logic.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse that launches a test; ignored unless idle.
REQ-007 SHALL have port base_addr  input  ADDR_W  burst start address, sampled on start.
REQ-008 SHALL have port len  input  8  AXI burst length (beats-1), sampled on start.
REQ-009 SHALL have port tid  input  ID_W  transaction ID, sampled on start.
REQ-010 SHALL have port seed  input  DATA_W  data-pattern seed, sampled on start.
REQ-011 SHALL have port busy  output  1  high from the cycle after start until done.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the test completes.
REQ-013 SHALL have port pass  output  1  valid from done onward: 1 when err_cnt is 0.
REQ-014 SHALL have port err_cnt  output  9  count of mismatched read beats.
REQ-015 SHALL have AW-channel ports awvalid(o,1), awready(i,1), awid(o,ID_W), awaddr(o,ADDR_W), awlen(o,8), awsize(o,3), awburst(o,2).
REQ-016 SHALL have W-channel ports wvalid(o,1), wready(i,1), wdata(o,DATA_W), wstrb(o,DATA_W/8), wlast(o,1).
REQ-017 SHALL have B-channel ports bvalid(i,1), bid(i,ID_W), bready(o,1).
REQ-018 SHALL have AR-channel ports arvalid(o,1), arready(i,1), arid(o,ID_W), araddr(o,ADDR_W), arlen(o,8), arsize(o,3), arburst(o,2).
REQ-019 SHALL have R-channel ports rvalid(i,1), rready(o,1), rid(i,ID_W), rdata(i,DATA_W), rlast(i,1).

Function
REQ-020 SHALL implement FSM IDLE->AW->W->B->AR->R->DONE->IDLE; a single AXI master issuing one write burst, then a read-back burst.
REQ-021 IDLE: start samples base_addr, len, tid, seed, clears err_cnt, moves to AW; busy rises the next cycle.
REQ-022 AW: awvalid=1, awaddr=base_addr, awlen=len, awid=tid, awsize=log2(DATA_W/8), awburst=2'b01 (INCR); leave on awvalid&&awready.
REQ-023 W: wvalid=1, wstrb all ones; beat k (0..len) carries pattern P(k); wlast=1 only on beat len; beat advances only on wvalid&&wready; leave after the wlast handshake.
REQ-024 Once asserted, valid and payload SHALL stay stable until the handshake (AXI rule); valid never depends combinationally on ready.
REQ-025 B: bready=1; leave on bvalid; bid!=tid adds 1 to err_cnt.
REQ-026 AR: mirrors AW on the AR channel with the same address, len, id, size and burst.
REQ-027 R: rready=1; each beat k compares rdata to P(k) and rid to tid, adding at most 1 to err_cnt per beat; leave on the rlast handshake.
REQ-028 An rlast before beat len, or no rlast at beat len, SHALL add 1 to err_cnt and end R at the rlast beat.
REQ-029 DONE: one cycle; done=1, busy=0 the same cycle; pass=(err_cnt==0) and holds until the next start.
REQ-030 Default pattern: P(k)=seed+k, modulo 2^DATA_W.
REQ-031 len=0 SHALL give one-beat bursts with wlast set on the first beat.
REQ-032 Address wrap beyond 2^ADDR_W is not checked; the caller keeps the burst within 4 KB.

Reset
REQ-033 rst_n low SHALL force IDLE immediately, mid-burst included; all valid/ready outputs, busy, done, pass, err_cnt go to 0.
REQ-034 Address, data and id outputs reset to 0; a burst aborted by reset is not resumed.

Configuration
REQ-035 With macro AXI_TG_LFSR_EN defined, P(0)=seed (or 1 if seed==0), P(k+1)=Galois LFSR step of P(k), taps x^32+x^22+x^2+x+1 for DATA_W=32.
REQ-036 Without AXI_TG_LFSR_EN, the incrementing pattern applies and no LFSR logic is built; the read phase regenerates P from the stored seed.

Structure
REQ-037 Package axi_tg_pkg SHALL hold the FSM state enum, AXI_BURST_INCR=2'b01 and the LFSR tap constant.
REQ-038 Sub-module axi_tg_lfsr (enable, load, seed, value) SHALL exist only when AXI_TG_LFSR_EN is defined.

Verification
REQ-039 Against axi_ram: start, base 0x0100, len 3, seed 0xA0 -> writes 0xA0..0xA3, reads back matching data, done pulse, pass=1, err_cnt=0.
REQ-040 len=0, base 0x0000 -> single beats with wlast=1 and rlast expected on beat 0; pass=1.
REQ-041 A model corrupting R beat 2 of len 7 -> err_cnt=1, pass=0.
REQ-042 Random wready/awready/arready stalls -> payloads stable while valid is held; result equals the no-stall run.
REQ-043 rst_n dropped during W beat 2 -> all outputs 0 next cycle; a new start runs cleanly to pass=1.
REQ-044 With AXI_TG_LFSR_EN, seed 0 -> the first wdata is 0x00000001 and read-back passes.
